// File: rtl/lc3b_types.sv
// Shared LC-3b types for the BTB write-side controller: word type, BTB
// geometry, the queued update record and the update FSM state encoding.
package lc3b_types;

   typedef logic [15:0] lc3b_word;

   localparam int BTB_WAYS = 4;

   typedef struct packed {
      lc3b_word pc;
      lc3b_word target;
   } btb_upd_entry_t;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOOKUP = 2'd1,
      WRITE  = 2'd2
   } btb_upd_state_t;

endpackage

// File: rtl/btb_way_pick.sv
// Combinational way selection for a BTB update: lowest matching way on a hit,
// otherwise the tree pseudo-LRU victim.
module btb_way_pick
   import lc3b_types::*;
(
   input  logic       wb_hit,
   input  logic       wb_comp0_out,
   input  logic       wb_comp1_out,
   input  logic       wb_comp2_out,
   input  logic       wb_comp3_out,
   input  logic [2:0] lru_out,
   output logic [1:0] way
);

   always_comb begin
      way = 2'd0;
      if (wb_hit) begin
         if (wb_comp0_out)      way = 2'd0;
         else if (wb_comp1_out) way = 2'd1;
         else if (wb_comp2_out) way = 2'd2;
         else if (wb_comp3_out) way = 2'd3;
      end else begin
         // bit 0 picks the half, bit 1 / bit 2 pick the way within it
         way = lru_out[0] ? {1'b1, lru_out[2]} : {1'b0, lru_out[1]};
      end
   end

endmodule

// File: rtl/btb_update_ctrl.sv
// Write-side BTB controller: queues resolved taken branches and drains each
// one via a borrowed lookup and a single-cycle way write.
// Optional statistics counters are enabled with `define BTB_UPDATE_STATS_EN.
//
// state  | meaning
// IDLE   | FIFO empty, nothing in flight
// LOOKUP | requesting the BTB read port for the head PC; way latched on grant
// WRITE  | one-cycle way write + LRU update, head popped at the edge
module btb_update_ctrl
   import lc3b_types::*;
#(
   parameter int DEPTH = 4
) (
   input  logic     clk,
   input  logic     reset,
   input  logic     res_valid,
   input  logic     res_taken,
   input  lc3b_word res_pc,
   input  lc3b_word res_target,
   output logic     res_ready,
   output logic     btb_rd_req,
   input  logic     btb_rd_gnt,
   input  logic     wb_hit,
   input  logic     wb_comp0_out,
   input  logic     wb_comp1_out,
   input  logic     wb_comp2_out,
   input  logic     wb_comp3_out,
   input  logic [2:0] lru_out,
   output lc3b_word old_pc_addr,
   output lc3b_word wb_addr,
   output logic     wb_enable,
   output logic     way0_write,
   output logic     way1_write,
   output logic     way2_write,
   output logic     way3_write,
   output logic     lru_load,
`ifdef BTB_UPDATE_STATS_EN
   output logic [15:0] stat_installs,
   output logic [15:0] stat_updates,
   output logic [15:0] stat_discards,
`endif
   output logic     upd_busy
);

   localparam int PW = $clog2(DEPTH);

   btb_upd_entry_t r_mem [DEPTH];
   logic [PW-1:0]  r_wr_ptr;
   logic [PW-1:0]  r_rd_ptr;
   logic [PW:0]    r_count;
   logic [PW:0]    w_count_nxt;
   logic           w_full;
   logic           w_empty;
   logic           w_xfer;
   logic           w_push;
   logic           w_pop;

   btb_upd_state_t r_state;
   btb_upd_state_t w_state_nxt;
   logic [1:0]     r_way;
   logic [1:0]     w_pick;
   logic           r_hit;

   assign w_full    = (r_count == (PW+1)'(DEPTH));
   assign w_empty   = (r_count == '0);
   assign res_ready = !w_full;
   assign w_xfer    = res_valid && res_ready;
   assign w_push    = w_xfer && res_taken;
   assign w_pop     = (r_state == WRITE);
   assign w_count_nxt = r_count + (PW+1)'(w_push) - (PW+1)'(w_pop);

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= '{pc: res_pc, target: res_target};
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
         r_count <= w_count_nxt;
      end
   end

   assign old_pc_addr = w_empty ? '0 : r_mem[r_rd_ptr].pc;
   assign wb_addr     = w_empty ? '0 : r_mem[r_rd_ptr].target;
   assign upd_busy    = !w_empty || (r_state != IDLE);

   btb_way_pick u_way_pick (
      .wb_hit       (wb_hit),
      .wb_comp0_out (wb_comp0_out),
      .wb_comp1_out (wb_comp1_out),
      .wb_comp2_out (wb_comp2_out),
      .wb_comp3_out (wb_comp3_out),
      .lru_out      (lru_out),
      .way          (w_pick)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= IDLE;
         r_way   <= 2'd0;
         r_hit   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         if (r_state == LOOKUP && btb_rd_gnt) begin
            r_way <= w_pick;
            r_hit <= wb_hit;
         end
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      btb_rd_req  = 1'b0;
      wb_enable   = 1'b0;
      lru_load    = 1'b0;
      way0_write  = 1'b0;
      way1_write  = 1'b0;
      way2_write  = 1'b0;
      way3_write  = 1'b0;
      case (r_state)
         IDLE: begin
            if (!w_empty) w_state_nxt = LOOKUP;
         end
         LOOKUP: begin
            btb_rd_req = 1'b1;
            if (btb_rd_gnt) w_state_nxt = WRITE;
         end
         WRITE: begin
            wb_enable  = 1'b1;
            lru_load   = 1'b1;
            way0_write = (r_way == 2'd0);
            way1_write = (r_way == 2'd1);
            way2_write = (r_way == 2'd2);
            way3_write = (r_way == 2'd3);
            // a same-cycle enqueue keeps the FIFO non-empty after the pop
            w_state_nxt = (w_count_nxt != '0) ? LOOKUP : IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

`ifdef BTB_UPDATE_STATS_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         stat_installs <= '0;
         stat_updates  <= '0;
         stat_discards <= '0;
      end else begin
         if (w_pop && !r_hit && stat_installs != 16'hFFFF)
            stat_installs <= stat_installs + 16'd1;
         if (w_pop && r_hit && stat_updates != 16'hFFFF)
            stat_updates <= stat_updates + 16'd1;
         if (w_xfer && !res_taken && stat_discards != 16'hFFFF)
            stat_discards <= stat_discards + 16'd1;
      end
   end
`endif

endmodule
